// File: rtl/reg_status_table_pkg.sv
// Shared types and the per-entry transition rule for the register status table.
// The entry state moves EMPTY -> BUSY/SPEC on a claim and back on release or squash.
package reg_status_table_pkg;

    typedef enum logic [1:0] {
        RST_EMPTY = 2'd0,
        RST_BUSY  = 2'd1,
        RST_SPEC  = 2'd2
    } rst_state_e;

    // A claim only ever reaches an EMPTY entry, so claim and release never collide.
    function automatic rst_state_e rst_next_state(
        input rst_state_e cur,
        input logic       claim,
        input logic       claim_spec,
        input logic       rel_hit,
        input logic       commit,
        input logic       squash
    );
        rst_state_e nxt;
        nxt = cur;
        if (claim) begin
            if (!claim_spec) begin
                nxt = RST_BUSY;
            end else if (squash) begin
                nxt = RST_EMPTY;
            end else if (commit) begin
                nxt = RST_BUSY;
            end else begin
                nxt = RST_SPEC;
            end
        end else begin
            case (cur)
                RST_EMPTY: nxt = RST_EMPTY;
                RST_BUSY:  nxt = rel_hit ? RST_EMPTY : RST_BUSY;
                RST_SPEC: begin
                    if (rel_hit || squash) begin
                        nxt = RST_EMPTY;
                    end else if (commit) begin
                        nxt = RST_BUSY;
                    end else begin
                        nxt = RST_SPEC;
                    end
                end
                default:   nxt = RST_EMPTY;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/reg_status_table_if.sv
// Dispatch, lookup, writeback and branch-resolve signals of the register status table.
interface reg_status_table_if #(
    parameter int NREGS = 32,
    parameter int TAG_W = 2,
    parameter int NRD   = 2,
    parameter int NWB   = 2
);
    localparam int IDX_W  = $clog2(NREGS);
    localparam int SCNT_W = $clog2(NREGS + 1);

    logic                   di_en;
    logic [IDX_W-1:0]       di_rd;
    logic [TAG_W-1:0]       di_tag;
    logic                   di_spec;
    logic                   di_ready;
    logic [NRD*IDX_W-1:0]   rd_idx;
    logic [NRD-1:0]         rd_busy;
    logic [NRD*TAG_W-1:0]   rd_tag;
    logic [NWB-1:0]         wb_en;
    logic [NWB*IDX_W-1:0]   wb_rd;
    logic [NWB*TAG_W-1:0]   wb_tag;
    logic                   br_resolve;
    logic                   br_mispredict;
    logic [NREGS-1:0]       busy_vec;
    logic [SCNT_W-1:0]      spec_cnt;

    modport master (
        output di_en, di_rd, di_tag, di_spec, rd_idx, wb_en, wb_rd, wb_tag,
               br_resolve, br_mispredict,
        input  di_ready, rd_busy, rd_tag, busy_vec, spec_cnt
    );

    modport slave (
        input  di_en, di_rd, di_tag, di_spec, rd_idx, wb_en, wb_rd, wb_tag,
               br_resolve, br_mispredict,
        output di_ready, rd_busy, rd_tag, busy_vec, spec_cnt
    );
endinterface

// File: rtl/reg_status_table_entry.sv
// One register's status row: state machine plus owner tag.
module reg_status_table_entry
    import reg_status_table_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int NWB   = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             claim_i,
    input  logic             claim_spec_i,
    input  logic [TAG_W-1:0] claim_tag_i,
    input  logic [NWB-1:0]   rel_match_i,
    input  logic             commit_i,
    input  logic             squash_i,
    output rst_state_e       state_o,
    output rst_state_e       state_d_o,
    output logic [TAG_W-1:0] tag_o
);
    typedef struct packed {
        rst_state_e       state;
        logic [TAG_W-1:0] tag;
    } row_t;

    row_t row_q;
    row_t row_d;

    // Next row; an entry that ends up EMPTY always carries tag 0.
    always_comb begin
        row_d       = row_q;
        row_d.state = rst_next_state(row_q.state, claim_i, claim_spec_i,
                                     |rel_match_i, commit_i, squash_i);
        if (row_d.state == RST_EMPTY) begin
            row_d.tag = '0;
        end else if (claim_i) begin
            row_d.tag = claim_tag_i;
        end else begin
            row_d.tag = row_q.tag;
        end
    end

    // Row register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            row_q.state <= RST_EMPTY;
            row_q.tag   <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign state_o   = row_q.state;
    assign state_d_o = row_d.state;
    assign tag_o     = row_q.tag;
endmodule

// File: rtl/reg_status_table.sv
// Register status table: per-register busy/owner/speculation tracking between
// dispatch (claims, lookups) and writeback (tag-checked releases).
module reg_status_table
    import reg_status_table_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int TAG_W    = 2,
    parameter int NRD      = 2,
    parameter int NWB      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    reg_status_table_if.slave bus
);
    localparam int IDX_W  = $clog2(NREGS);
    localparam int SCNT_W = $clog2(NREGS + 1);

    rst_state_e                    state_s   [NREGS];
    rst_state_e                    state_d_s [NREGS];
    logic [TAG_W-1:0]              tag_s     [NREGS];
    logic [NREGS-1:0]              busy_s;
    logic [NREGS-1:0]              claim_s;
    logic [NREGS-1:0][NWB-1:0]     rel_s;
    logic                          di_ready_s;
    logic                          commit_s;
    logic                          squash_s;
    logic [NRD-1:0]                rd_busy_s;
    logic [NRD*TAG_W-1:0]          rd_tag_s;
    logic [SCNT_W-1:0]             spec_cnt_d;
    logic [SCNT_W-1:0]             spec_cnt_q;

    assign commit_s = bus.br_resolve & ~bus.br_mispredict;
    assign squash_s = bus.br_resolve &  bus.br_mispredict;

    // Destination decode for the WAW stall.
    always_comb begin
        di_ready_s = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            di_ready_s = di_ready_s & ~(busy_s[i] & (bus.di_rd == IDX_W'(i)));
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_entry
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign claim_s[i] = 1'b0;
        end else begin : g_claim
            assign claim_s[i] = bus.di_en & di_ready_s & (bus.di_rd == IDX_W'(i));
        end

        // A writeback only frees the entry when it comes from the current owner.
        for (genvar p = 0; p < NWB; p++) begin : g_rel
            assign rel_s[i][p] = bus.wb_en[p]
                               & (bus.wb_rd[p*IDX_W +: IDX_W] == IDX_W'(i))
                               & (bus.wb_tag[p*TAG_W +: TAG_W] == tag_s[i]);
        end

        reg_status_table_entry #(
            .TAG_W (TAG_W),
            .NWB   (NWB)
        ) u_entry (
            .clk_i        (CLK),
            .rst_n_i      (nRST),
            .claim_i      (claim_s[i]),
            .claim_spec_i (bus.di_spec),
            .claim_tag_i  (bus.di_tag),
            .rel_match_i  (rel_s[i]),
            .commit_i     (commit_s),
            .squash_i     (squash_s),
            .state_o      (state_s[i]),
            .state_d_o    (state_d_s[i]),
            .tag_o        (tag_s[i])
        );

        assign busy_s[i] = (state_s[i] != RST_EMPTY);
    end

    // Source lookups from registered state only.
    always_comb begin
        rd_busy_s = '0;
        rd_tag_s  = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int i = 0; i < NREGS; i++) begin
                rd_busy_s[p] = rd_busy_s[p]
                             | (busy_s[i] & (bus.rd_idx[p*IDX_W +: IDX_W] == IDX_W'(i)));
                rd_tag_s[p*TAG_W +: TAG_W] = rd_tag_s[p*TAG_W +: TAG_W]
                    | ({TAG_W{busy_s[i] & (bus.rd_idx[p*IDX_W +: IDX_W] == IDX_W'(i))}}
                       & tag_s[i]);
            end
        end
    end

    // Popcount of SPEC entries after this edge's update.
    always_comb begin
        spec_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            spec_cnt_d = spec_cnt_d + SCNT_W'(state_d_s[i] == RST_SPEC);
        end
    end

    // Speculative-entry counter register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            spec_cnt_q <= '0;
        end else begin
            spec_cnt_q <= spec_cnt_d;
        end
    end

    assign bus.di_ready = di_ready_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.rd_tag   = rd_tag_s;
    assign bus.busy_vec = busy_s;
    assign bus.spec_cnt = spec_cnt_q;
endmodule
